// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle for mem_port_arbiter.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface mem_port_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    Req;
  logic [NREQ-1:0]    Lock;
  logic [NREQ-1:0]    WrEn;
  logic [NREQ*AW-1:0] Addr;
  logic [NREQ*DW-1:0] WrData;
  logic [NREQ-1:0]    Gnt;
  logic [NREQ-1:0]    RdValid;
  logic [DW-1:0]      RdData;
  logic [NREQ-1:0]    Err;
  logic [AW-1:0]      Mem_Address;
  logic [DW-1:0]      Mem_DataIn;
  logic               Mem_WriteEna;
  logic               Mem_ReadEna;
  logic [DW-1:0]      Mem_DataOut;

  modport slave (
    input  Req, Lock, WrEn, Addr, WrData, Mem_DataOut,
    output Gnt, RdValid, RdData, Err,
           Mem_Address, Mem_DataIn, Mem_WriteEna, Mem_ReadEna
  );

  modport master (
    output Req, Lock, WrEn, Addr, WrData, Mem_DataOut,
    input  Gnt, RdValid, RdData, Err,
           Mem_Address, Mem_DataIn, Mem_WriteEna, Mem_ReadEna
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with locked bursts in front of one memory port.
// Optional out-of-range beat suppression: define MEM_ARB_BOUNDS_CHECK_EN.
module mem_port_arbiter #(
  parameter int NREQ      = 3,
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   acc_idx_s;
  logic            acc_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_wdata_s;
  logic            sel_we_s;
  logic            oob_s;

  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            we_q;
  logic            re_q;
  logic [NREQ-1:0] err_q;
  logic [NREQ-1:0] tag_q [0:READ_LAT];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant selection and arbitration next state; the grant itself is never registered.
  always_comb begin
    int   idx;
    logic found;
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt_s     = '0;
    acc_idx_s = '0;
    idx       = 0;
    found     = 1'b0;
    case (state_q)
      ARB: begin
        for (int j = 1; j <= NREQ; j++) begin
          idx = (int'(last_q) + j) % NREQ;
          if (!found && bus.Req[idx]) begin
            found      = 1'b1;
            gnt_s[idx] = 1'b1;
            acc_idx_s  = IW'(idx);
          end
        end
        if (found) begin
          last_d = acc_idx_s;
          if (bus.Lock[acc_idx_s] && (MAX_BURST > 1)) begin
            state_d = BURST;
            owner_d = acc_idx_s;
            cnt_d   = CW'(1);
          end
        end
      end
      BURST: begin
        acc_idx_s = owner_q;
        if (bus.Req[owner_q]) begin
          gnt_s[owner_q] = 1'b1;
          cnt_d          = cnt_q + CW'(1);
          if (!bus.Lock[owner_q] || (int'(cnt_q) + 1 >= MAX_BURST)) begin
            state_d = ARB;
            last_d  = owner_q;
          end
        end else begin
          // Owner paused: give up the port with one idle cycle.
          state_d = ARB;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  assign acc_s       = |gnt_s;
  assign sel_addr_s  = bus.Addr[int'(acc_idx_s)*AW +: AW];
  assign sel_wdata_s = bus.WrData[int'(acc_idx_s)*DW +: DW];
  assign sel_we_s    = bus.WrEn[acc_idx_s];

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  assign oob_s = (int'(sel_addr_s) >= DEPTH);
`else
  assign oob_s = 1'b0;
`endif

  // Memory drive and read-tag pipe; a tag reaching the last stage is the read return strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= '0;
      for (int j = 0; j <= READ_LAT; j++) begin
        tag_q[j] <= '0;
      end
    end else begin
      if (acc_s) begin
        addr_q  <= sel_addr_s;
        wdata_q <= sel_wdata_s;
        we_q    <= sel_we_s & ~oob_s;
        re_q    <= ~sel_we_s & ~oob_s;
        err_q   <= oob_s ? gnt_s : '0;
      end else begin
        we_q  <= 1'b0;
        re_q  <= 1'b0;
        err_q <= '0;
      end
      tag_q[0] <= (acc_s && !sel_we_s && !oob_s) ? gnt_s : '0;
      for (int j = 1; j <= READ_LAT; j++) begin
        tag_q[j] <= tag_q[j-1];
      end
    end
  end

  assign bus.Gnt          = RST_N ? gnt_s : '0;
  assign bus.Mem_Address  = addr_q;
  assign bus.Mem_DataIn   = wdata_q;
  assign bus.Mem_WriteEna = we_q;
  assign bus.Mem_ReadEna  = re_q;
  assign bus.Err          = err_q;
  assign bus.RdValid      = tag_q[READ_LAT];
  assign bus.RdData       = bus.Mem_DataOut;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a rule-level arbitration and memory model.
module tb_mem_port_arbiter;
  localparam int NREQ = 3, AW = 16, DW = 16, DEPTH = 1024, READ_LAT = 1, MAX_BURST = 4;
  localparam int NSCHED = 8192;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Memory with one-clock registered read, fed from the DUT's memory port.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] dout = '0;
  assign bus.Mem_DataOut = dout;
  initial begin
    logic          cw, cr;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    forever begin
      @(negedge CLK);
      cw = bus.Mem_WriteEna; cr = bus.Mem_ReadEna; ca = bus.Mem_Address; cd = bus.Mem_DataIn;
      @(posedge CLK);
      if (cw) mem[ca[9:0]] = cd;
      if (cr) dout = mem[ca[9:0]];
    end
  end

  int n_vec = 0, n_chk = 0, n_fail = 0, cyc = 0;
  int m_last, m_owner, m_beats;
  bit m_burst;
  logic [DW-1:0]   shadow [0:DEPTH-1];
  logic [NREQ-1:0] sch_v [0:NSCHED-1];
  logic [DW-1:0]   sch_d [0:NSCHED-1];
  logic            exp_we, exp_re;
  logic [AW-1:0]   exp_addr;
  logic [DW-1:0]   exp_data;
  logic [NREQ-1:0] exp_err;
  logic [NREQ-1:0] dut_gnt;

  int left [NREQ];
  bit lk [NREQ];
  int wmode [NREQ];
  int fa [NREQ];
  int fd [NREQ];
  bit rand_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = NREQ - 1; m_burst = 1'b0; m_owner = 0; m_beats = 0;
    exp_we = 1'b0; exp_re = 1'b0; exp_addr = '0; exp_data = '0; exp_err = '0;
    for (int i = 0; i < NSCHED; i++) begin sch_v[i] = '0; sch_d[i] = '0; end
  endtask

  // Round-robin winner scanning cyclically after the last owner, or the locked owner only.
  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (m_burst) begin
      if (bus.Req[m_owner]) g[m_owner] = 1'b1;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        int i;
        i = (m_last + off) % NREQ;
        if (g == '0 && bus.Req[i]) g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic new_beat(input int i);
    logic [AW-1:0] a;
    bus.WrEn[i] = (wmode[i] == 2) ? 1'($urandom_range(1)) : (wmode[i] == 1);
    if (fa[i] >= 0) a = 16'(fa[i]);
    else if (rand_mode && $urandom_range(7) == 0) a = 16'($urandom);
    else a = 16'($urandom_range(DEPTH - 1));
    bus.Addr[i*AW +: AW] = a;
    bus.WrData[i*DW +: DW] = (fd[i] >= 0) ? 16'(fd[i]) : 16'($urandom);
  endtask

  task automatic apply_req();
    for (int i = 0; i < NREQ; i++) begin
      bus.Req[i]  = (left[i] > 0);
      bus.Lock[i] = lk[i] && (left[i] > 0);
    end
  endtask

  task automatic load(input int i, input int n, input bit lock, input int wm, input int addr, input int data);
    left[i] = n; lk[i] = lock; wmode[i] = wm; fa[i] = addr; fd[i] = data;
    new_beat(i);
    apply_req();
  endtask

  task automatic drive_update();
    for (int i = 0; i < NREQ; i++) begin
      if (dut_gnt[i] && left[i] > 0) begin
        left[i]--;
        if (left[i] > 0) new_beat(i);
      end
      if (rand_mode && left[i] == 0 && $urandom_range(2) == 0) begin
        left[i] = $urandom_range(5, 1); lk[i] = 1'($urandom_range(1));
        wmode[i] = 2; fa[i] = -1; fd[i] = -1;
        new_beat(i);
      end
    end
    apply_req();
  endtask

  // One clock: compare everything against the model at the negedge, then advance the model.
  task automatic step();
    logic [NREQ-1:0] eg;
    logic [AW-1:0]   a;
    logic [DW-1:0]   wd;
    logic            w, oob;
    int              gi;
    @(negedge CLK);
    eg = model_gnt();
    dut_gnt = bus.Gnt;
    chk("gnt", 32'(bus.Gnt), 32'(eg));
    chk("mem_we", 32'(bus.Mem_WriteEna), 32'(exp_we));
    chk("mem_re", 32'(bus.Mem_ReadEna), 32'(exp_re));
    chk("mem_addr", 32'(bus.Mem_Address), 32'(exp_addr));
    chk("mem_din", 32'(bus.Mem_DataIn), 32'(exp_data));
    chk("err", 32'(bus.Err), 32'(exp_err));
    chk("rd_valid", 32'(bus.RdValid), 32'(sch_v[cyc]));
    if (sch_v[cyc] != '0) chk("rd_data", 32'(bus.RdData), 32'(sch_d[cyc]));
    gi = -1;
    for (int i = 0; i < NREQ; i++) if (eg[i]) gi = i;
    if (gi >= 0) begin
      a = bus.Addr[gi*AW +: AW]; wd = bus.WrData[gi*DW +: DW]; w = bus.WrEn[gi];
      oob = BOUNDS && (int'(a) >= DEPTH);
      exp_addr = a; exp_data = wd;
      exp_we = w && !oob; exp_re = !w && !oob;
      exp_err = oob ? eg : '0;
      if (!w && !oob) begin
        sch_v[cyc + 1 + READ_LAT] = eg;
        sch_d[cyc + 1 + READ_LAT] = shadow[int'(a) % DEPTH];
      end
      if (w && !oob) shadow[int'(a) % DEPTH] = wd;
    end else begin
      exp_we = 1'b0; exp_re = 1'b0; exp_err = '0;
    end
    if (m_burst) begin
      if (gi >= 0) begin
        m_beats++;
        if (!bus.Lock[m_owner] || m_beats >= MAX_BURST) begin m_burst = 1'b0; m_last = m_owner; end
      end else begin
        m_burst = 1'b0; m_last = m_owner;
      end
    end else if (gi >= 0) begin
      m_last = gi;
      if (bus.Lock[gi] && MAX_BURST > 1) begin m_burst = 1'b1; m_owner = gi; m_beats = 1; end
    end
    cyc++; n_vec++;
    @(posedge CLK); #1;
    drive_update();
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      bit busy;
      busy = 1'b0;
      for (int i = 0; i < NREQ; i++) if (left[i] > 0) busy = 1'b1;
      if (busy) step();
    end
    for (int i = 0; i < NREQ; i++) chk("drain_done", 32'(left[i]), 32'd0);
    repeat (4) step();
  endtask

  initial begin
    logic [2:0] seq [0:7];
    bus.Req = '0; bus.Lock = '0; bus.WrEn = '0; bus.Addr = '0; bus.WrData = '0;
    dut_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; lk[i] = 0; wmode[i] = 0; fa[i] = -1; fd[i] = -1; end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    model_reset();

    #1;
    chk("rst_gnt", 32'(bus.Gnt), 32'd0);
    chk("rst_we", 32'(bus.Mem_WriteEna), 32'd0);
    chk("rst_re", 32'(bus.Mem_ReadEna), 32'd0);
    chk("rst_rdvalid", 32'(bus.RdValid), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Plain round robin, all three requesting.
    for (int i = 0; i < NREQ; i++) load(i, 2, 1'b0, 0, -1, -1);
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_gnt", 32'(dut_gnt), 32'(seq[k]));
    end
    repeat (3) step();

    // Write then read back through requester 1.
    load(1, 1, 1'b0, 1, 16'h0005, 16'hBEEF);
    step();
    load(1, 1, 1'b0, 0, 16'h0005, -1);
    step();
    chk("wr_rd_re", 32'(bus.Mem_ReadEna), 32'd1);
    chk("wr_rd_addr", 32'(bus.Mem_Address), 32'h0005);
    step();
    chk("wr_rd_valid", 32'(bus.RdValid), 32'b010);
    chk("wr_rd_data", 32'(bus.RdData), 32'hBEEF);
    repeat (2) step();

    // Out-of-range read by requester 2.
    load(2, 1, 1'b0, 0, 16'h0400, -1);
    step();
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    chk("oob_err", 32'(bus.Err), 32'b100);
    chk("oob_re", 32'(bus.Mem_ReadEna), 32'd0);
    step();
    chk("oob_norv", 32'(bus.RdValid), 32'd0);
`else
    chk("oob_err", 32'(bus.Err), 32'd0);
    chk("oob_addr", 32'(bus.Mem_Address), 32'h0400);
    chk("oob_re", 32'(bus.Mem_ReadEna), 32'd1);
    step();
`endif
    repeat (2) step();

    // Burst cap: req0 locks for six beats while req2 waits.
    load(2, 1, 1'b0, 0, -1, -1);
    step();
    load(0, 6, 1'b1, 0, -1, -1);
    load(2, 1, 1'b0, 0, -1, -1);
    seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b001; seq[3] = 3'b001;
    seq[4] = 3'b100; seq[5] = 3'b001; seq[6] = 3'b001; seq[7] = 3'b000;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("cap_gnt", 32'(dut_gnt), 32'(seq[k]));
    end

    // Burst release: owner pauses, port idles a cycle, then req1 wins.
    load(0, 2, 1'b1, 0, -1, -1);
    step();
    chk("rel_gnt0", 32'(dut_gnt), 32'b001);
    step();
    chk("rel_gnt1", 32'(dut_gnt), 32'b001);
    load(1, 1, 1'b0, 0, -1, -1);
    step();
    chk("rel_idle", 32'(dut_gnt), 32'b000);
    chk("rel_we", 32'(bus.Mem_WriteEna), 32'd0);
    chk("rel_re", 32'(bus.Mem_ReadEna), 32'd0);
    step();
    chk("rel_gnt1st", 32'(dut_gnt), 32'b010);
    repeat (3) step();

    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    drain();

    // Reset in the middle of a read burst with a read in flight.
    load(0, 4, 1'b1, 0, -1, -1);
    step();
    step();
    RST_N = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.Gnt), 32'd0);
    chk("mid_rst_rdvalid", 32'(bus.RdValid), 32'd0);
    chk("mid_rst_err", 32'(bus.Err), 32'd0);
    chk("mid_rst_we", 32'(bus.Mem_WriteEna), 32'd0);
    chk("mid_rst_re", 32'(bus.Mem_ReadEna), 32'd0);
    chk("mid_rst_addr", 32'(bus.Mem_Address), 32'd0);
    chk("mid_rst_din", 32'(bus.Mem_DataIn), 32'd0);
    chk("mid_rst_rddata", 32'(bus.RdData), 32'(bus.Mem_DataOut));
    model_reset();
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    apply_req();
    @(posedge CLK);
    @(posedge CLK);
    for (int i = 0; i < NREQ; i++) load(i, 1, 1'b0, 0, -1, -1);
    #1;
    RST_N = 1'b1;
    step();
    chk("post_rst_gnt", 32'(dut_gnt), 32'b001);
    repeat (4) step();

    rand_mode = 1'b1;
    repeat (200) step();
    rand_mode = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one port of the 16-bit x 1k two-port memory between NREQ requesters, such as instruction fetch, data load/store and DMA. Arbitration is round-robin with a per-requester request/grant handshake and optional locked bursts. The block registers the winning beat onto the memory port and routes read data back to the issuing requester with a one-hot valid. One instance sits in front of each memory port.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 16, address width
DW, 16, data width
DEPTH, 1024, memory words; used only by the bounds check
READ_LAT, 1, memory read latency in clocks from the address-sampling edge to valid DataOut
MAX_BURST, 4, maximum consecutive locked beats per owner (1 = Lock ignored)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
Req  in  NREQ  per-requester beat request; held until granted
Lock  in  NREQ  request to keep ownership for the next beat
WrEn  in  NREQ  1 = write beat, 0 = read beat
Addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
WrData  in  NREQ*DW  packed write data
Gnt  out  NREQ  one-hot grant, combinational
RdValid  out  NREQ  one-hot read-return strobe
RdData  out  DW  read data, valid when any RdValid bit is set
Err  out  NREQ  out-of-range beat strobe (see Optional Feature)
Mem_Address  out  AW  to memory Address_n
Mem_DataIn  out  DW  to memory DataIn_n
Mem_WriteEna  out  1  to memory WriteEna_n
Mem_ReadEna  out  1  to memory ReadEna_n
Mem_DataOut  in  DW  from memory DataOut_n

Behaviour:
- Reset (RST_N low, async):
  - FSM=ARB, pointer Last=NREQ-1, burst count=0.
  - Read-tag pipe cleared; in-flight reads are discarded, with no stale RdValid after release.
  - Gnt=0, RdValid=0, Err=0, Mem_WriteEna=0, Mem_ReadEna=0, Mem_Address=0, Mem_DataIn=0.
  - RdData=Mem_DataOut (pass-through).
- Accept: a beat from requester i is accepted at rising edge k when Req[i]&Gnt[i]. At most one beat per cycle.
- Memory drive (registered):
  - Between edges k and k+1: Mem_Address=Addr[i], Mem_DataIn=WrData[i], Mem_WriteEna=WrEn[i], Mem_ReadEna=~WrEn[i].
  - Cycles with no accepted beat: both enables 0; address/data hold their last value.
- Read return: for a read accepted at edge k, RdValid[i]=1 and RdData valid between edges k+READ_LAT and k+READ_LAT+1. Back-to-back reads return back-to-back, in order.
- ARB state:
  - Gnt = first i with Req[i] set, scanning cyclically from Last+1.
  - On accept: Last=i.
  - If Lock[i] and MAX_BURST>1: go to BURST with owner=i, count=1.
- BURST state:
  - Gnt[owner]=Req[owner]; all other Gnt bits 0.
  - On accept: count+1. Return to ARB when that beat has Lock=0 or count reaches MAX_BURST.
  - If Req[owner]=0 in any BURST cycle: no grant that cycle, return to ARB (one idle cycle).
  - On leaving BURST, Last=owner, so the other requesters are scanned first.
- Simultaneous requests in ARB: only the round-robin winner is granted; losers keep Req held.
- Reset mid-burst: behaves as reset above; the first grant after release goes to the lowest-index requesting port.
- Req changes after a grant are sampled only at the edge; the grant is never registered.

Optional Feature:
MEM_ARB_BOUNDS_CHECK_EN
- Defined:
  - A beat with Addr >= DEPTH is still accepted normally (Gnt, pointer and burst count update).
  - Memory enables stay 0 for that beat's drive cycle; Err[i] pulses in that same cycle.
  - No RdValid is produced for an out-of-range read.
- Undefined:
  - Err tied to 0.
  - The address passes through unchanged; the memory aliases on its low bits.

Test Plan:
- Reset: drop RST_N mid-burst with a read in flight -> all outputs 0 immediately, no RdValid after release; with Req=3'b111, first Gnt=3'b001.
- Round-robin: Req=3'b111 held, Lock=0 -> Gnt sequence 001,010,100,001,010,100, one beat per cycle, enables high every cycle.
- Write/read: req1 writes 16'hBEEF to 16'h0005, then reads 16'h0005 at edge k -> RdValid=3'b010, RdData=16'hBEEF in the cycle after edge k+1 (READ_LAT=1).
- Burst cap: req0 Req+Lock for 6 beats, req2 Req held -> Gnt 001 x4, then 100, then 001 x2.
- Burst release: req0 locks, then drops Req for one cycle -> one cycle with Gnt=0 and enables 0; next cycle ARB grants req1 if it is requesting.
- Bounds (macro defined): req2 reads 16'h0400 -> Err=3'b100 for one cycle, Mem_ReadEna=0, no RdValid. Macro undefined -> Err=0, Mem_Address=16'h0400, Mem_ReadEna=1.
